unified_mem_arbiter: RTL

- Shares one single-ported unified memory between the IF-stage instruction fetch port and the MEM-stage data port of the 5-stage pipeline.
- Sequences each access over a fixed multi-cycle memory latency and returns a registered one-cycle ready pulse per port.
- Drives a combinational pipeline stall, which feeds the existing PC hold, IF/ID hold and ID/EX flush logic.
- Data port has priority. Fetch is protected from starvation.

---
 rtl/unified_mem_arbiter_pkg.sv | 9 +
 rtl/unified_mem_arbiter_if.sv | 30 +++
 rtl/unified_mem_arbiter_mem_lat_counter.sv | 15 +
 rtl/unified_mem_arbiter.sv | 75 +++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared state encoding and default latency for the unified memory arbiter.
package unified_mem_arbiter_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DACC = 2'd1,
        ARB_IACC = 2'd2
    } arbState_t;
    localparam int DEF_MEM_LAT = 2;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, data and memory-side signals of the unified memory arbiter.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_rd;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              pipe_stall;
    modport master (
        output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata, pipe_stall
    );
    modport slave (
        input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata, pipe_stall
    );
endinterface

// File: rtl/unified_mem_arbiter_mem_lat_counter.sv
// mem_lat_counter: loadable down-counter timing one memory access; done marks the last access cycle.
module mem_lat_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       active,
    input  logic [3:0] value,
    output logic       done
);
    logic [3:0] cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= 4'd0;
        else cnt <= load ? value : (active && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    assign done = active && cnt == 4'd0;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between fetch and data ports, data first, fetch never starved.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input logic clk,
    input logic reset,
    unified_mem_arbiter_if.slave bus
);
    arbState_t state, nextState;
    logic lastD, isRead, done, dOk, iOk, grantD, grantI;
    logic memEn, memWe, ifReady, dmReady;
    logic [ADDR_W-1:0] memAddr, grantAddr;
    logic [DATA_W-1:0] memWdata, ifRdata, dmRdata;
    // The just-completed request is still asserted during its ready cycle and must not re-arbitrate.
    assign dOk = (bus.dm_rd | bus.dm_wr) & ~dmReady;
    assign iOk = bus.if_req & ~ifReady;
    always_comb begin
        grantD    = state == ARB_IDLE && dOk && !(iOk && lastD);
        grantI    = state == ARB_IDLE && iOk && !grantD;
        grantAddr = grantD ? bus.dm_addr : bus.if_addr;
        nextState = grantD ? ARB_DACC : grantI ? ARB_IACC : done ? ARB_IDLE : state;
    end
    mem_lat_counter u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load   (grantD | grantI),
        .active (state != ARB_IDLE),
        .value  (4'(MEM_LAT - 1)),
        .done   (done)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= ARB_IDLE;
            lastD    <= 1'b0;
            isRead   <= 1'b0;
            memEn    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            ifRdata  <= '0;
            dmRdata  <= '0;
            ifReady  <= 1'b0;
            dmReady  <= 1'b0;
        end else begin
            state   <= nextState;
            ifReady <= done && state == ARB_IACC;
            dmReady <= done && state == ARB_DACC;
            if (grantD || grantI) begin
                lastD    <= grantD;
                isRead   <= grantD && bus.dm_rd;
                memEn    <= 1'b1;
                memWe    <= grantD && bus.dm_wr;
                memAddr  <= grantAddr;
                memWdata <= bus.dm_wdata;
            end else if (done) begin
                memEn <= 1'b0;
                memWe <= 1'b0;
            end
            if (done && state == ARB_DACC && isRead) dmRdata <= bus.mem_rdata;
            if (done && state == ARB_IACC) ifRdata <= bus.mem_rdata;
        end
    assign bus.mem_en     = memEn;
    assign bus.mem_we     = memWe;
    assign bus.mem_addr   = memAddr;
    assign bus.mem_wdata  = memWdata;
    assign bus.if_rdata   = ifRdata;
    assign bus.dm_rdata   = dmRdata;
    assign bus.if_ready   = ifReady;
    assign bus.dm_ready   = dmReady;
    assign bus.pipe_stall = iOk | dOk;
endmodule
